// File: rtl/divider_period_detector.sv
// Recovers the Scale setting of a divided clock by timing its half-periods in sysclk cycles.
// Define SYNC_EN to insert a 2-flop synchronizer so Slow_clk may be asynchronous to sysclk.
module divider_period_detector #(
    parameter int CNT_W      = 8,
    parameter int SCALE_W    = 6,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               Slow_clk,
    output logic [CNT_W-1:0]   Half_period,
    output logic               Meas_valid,
    output logic [SCALE_W-1:0] Scale_out,
    output logic               Locked,
    output logic               Timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
    localparam logic [3:0]       LOCK_N    = 4'(LOCK_COUNT);
    localparam logic [31:0]      SCALE_MAX = (32'd1 << SCALE_W) - 32'd1;

    // Level of Slow_clk as seen by the edge detector
    logic slow_s;

`ifdef SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= {2{Slow_clk}};
        end else begin
            sync_q <= {sync_q[0], Slow_clk};
        end
    end

    assign slow_s = sync_q[1];
`else
    assign slow_s = Slow_clk;
`endif

    state_t             state_q, state_d;
    logic               prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         match_q, match_d;
    logic [CNT_W-1:0]   ref_q, ref_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic               valid_q, valid_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic               edge_w;
    logic [CNT_W-1:0]   diff_w;
    logic               within_w;
    logic [31:0]        ref_m1_w;
    logic [SCALE_W-1:0] scale_sat_w;
    logic [3:0]         match_inc_w;

    always_comb begin
        edge_w      = slow_s ^ prev_q;
        diff_w      = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
        within_w    = (diff_w <= TOL_V);
        match_inc_w = match_q + 4'd1;
        // A lock is only declared on the match path, so ref_q is already the locked period.
        ref_m1_w    = 32'(ref_q) - 32'd1;
        scale_sat_w = (ref_m1_w > SCALE_MAX) ? '1 : SCALE_W'(ref_m1_w);
    end

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        ref_d     = ref_q;
        half_d    = half_q;
        valid_d   = 1'b0;
        scale_d   = scale_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (edge_w) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // An edge always takes priority over a simultaneous saturation.
        if (edge_w) begin
            timeout_d = 1'b0;
            case (state_q)
                IDLE: begin
                    state_d = ACQ;
                end
                ACQ: begin
                    valid_d = 1'b1;
                    half_d  = cnt_q;
                    if ((match_q != 4'd0) && within_w) begin
                        match_d = match_inc_w;
                        if (match_inc_w == LOCK_N) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                            scale_d  = scale_sat_w;
                        end
                    end else begin
                        match_d = 4'd1;
                        ref_d   = cnt_q;
                    end
                end
                LOCK: begin
                    valid_d = 1'b1;
                    half_d  = cnt_q;
                    if (!within_w) begin
                        state_d  = ACQ;
                        locked_d = 1'b0;
                        ref_d    = cnt_q;
                        match_d  = 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
            match_d   = 4'd0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= Slow_clk;
            cnt_q     <= '0;
            match_q   <= 4'd0;
            ref_q     <= '0;
            half_q    <= '0;
            valid_q   <= 1'b0;
            scale_q   <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= slow_s;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            ref_q     <= ref_d;
            half_q    <= half_d;
            valid_q   <= valid_d;
            scale_q   <= scale_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign Half_period = half_q;
    assign Meas_valid  = valid_q;
    assign Scale_out   = scale_q;
    assign Locked      = locked_q;
    assign Timeout     = timeout_q;

endmodule

// File: tb/tb_divider_period_detector.sv
// Table-driven bench for divider_period_detector: expected measurements are queued when
// Slow_clk toggles and compared when Meas_valid pulses.
`timescale 1ns/1ps
module tb_divider_period_detector;

`ifdef SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slow = 1'b0;
    logic       slow_t = 1'b0;

    logic [7:0] half;
    logic       meas;
    logic [5:0] scale;
    logic       locked;
    logic       tmo;

    logic [7:0] half_t;
    logic       meas_t;
    logic [5:0] scale_t;
    logic       locked_t;
    logic       tmo_t;

    divider_period_detector dut (
        .sysclk      (clk),
        .reset       (rst),
        .Slow_clk    (slow),
        .Half_period (half),
        .Meas_valid  (meas),
        .Scale_out   (scale),
        .Locked      (locked),
        .Timeout     (tmo)
    );

    divider_period_detector #(.TOL(1)) dut_tol (
        .sysclk      (clk),
        .reset       (rst),
        .Slow_clk    (slow_t),
        .Half_period (half_t),
        .Meas_valid  (meas_t),
        .Scale_out   (scale_t),
        .Locked      (locked_t),
        .Timeout     (tmo_t)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        bit v;
        int hp;
        bit lk;
        int sc;
    } vec_t;

    typedef struct {
        int hp;
        bit lk;
        int sc;
    } exp_t;

    vec_t tbl [0:28];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_pulse = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Scoreboard side: every Meas_valid pulse consumes one expected record.
    always @(negedge clk) begin
        exp_t e;
        if (meas) begin
            last_pulse = cyc;
            if (sb.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("half_period", int'(half), e.hp);
                check("locked", int'(locked), int'(e.lk));
                check("scale_out", int'(scale), e.sc);
                check("timeout_at_meas", int'(tmo), 0);
                $display("meas hp=%0d locked=%0d scale=%0d (exp %0d/%0d/%0d)",
                         half, locked, scale, e.hp, e.lk, e.sc);
            end
        end
    end

    task automatic apply(input int i);
        exp_t e;
        repeat (tbl[i].p) @(negedge clk);
        slow = ~slow;
        if (tbl[i].v) begin
            e.hp = tbl[i].hp;
            e.lk = tbl[i].lk;
            e.sc = tbl[i].sc;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        repeat (LAT + 2) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_half"}, int'(half), 0);
        check({tag, "_meas"}, int'(meas), 0);
        check({tag, "_scale"}, int'(scale), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_timeout"}, int'(tmo), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tp [0:4];
        int i;

        // Steady P=3, then P=10, P=100 (scale saturates), P=1.
        tbl[0] = '{3, 1'b0, 0, 1'b0, 0};
        for (int k = 1; k <= 3; k++) tbl[k] = '{3, 1'b1, 3, 1'b0, 0};
        tbl[4] = '{3, 1'b1, 3, 1'b1, 2};
        tbl[5] = '{3, 1'b1, 3, 1'b1, 2};
        for (int k = 6; k <= 8; k++) tbl[k] = '{10, 1'b1, 10, 1'b0, 2};
        tbl[9]  = '{10, 1'b1, 10, 1'b1, 9};
        tbl[10] = '{10, 1'b1, 10, 1'b1, 9};
        for (int k = 11; k <= 13; k++) tbl[k] = '{100, 1'b1, 100, 1'b0, 9};
        tbl[14] = '{100, 1'b1, 100, 1'b1, 63};
        for (int k = 15; k <= 17; k++) tbl[k] = '{1, 1'b1, 1, 1'b0, 63};
        tbl[18] = '{1, 1'b1, 1, 1'b1, 0};
        // After timeout: first edge gives no measurement.
        tbl[19] = '{5, 1'b0, 0, 1'b0, 0};
        for (int k = 20; k <= 22; k++) tbl[k] = '{3, 1'b1, 3, 1'b0, 0};
        tbl[23] = '{3, 1'b1, 3, 1'b1, 2};
        // After mid-operation reset: relock needs 1+LOCK_COUNT edges.
        tbl[24] = '{4, 1'b0, 0, 1'b0, 0};
        for (int k = 25; k <= 27; k++) tbl[k] = '{3, 1'b1, 3, 1'b0, 0};
        tbl[28] = '{3, 1'b1, 3, 1'b1, 2};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int k = 0; k <= 18; k++) apply(k);
        drain("seg1_drained");

        // Slow_clk stuck while locked.
        i = 0;
        while (i < 400 && !tmo) begin
            @(negedge clk);
            i++;
        end
        check("timeout_level", int'(tmo), 1);
        check("timeout_delay", cyc - last_pulse, 255);
        check("timeout_locked", int'(locked), 0);
        $display("timeout after %0d cycles", cyc - last_pulse);

        for (int k = 19; k <= 23; k++) apply(k);
        drain("seg2_drained");
        check("relock_after_timeout", int'(locked), 1);

        // One-cycle reset while locked.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");

        for (int k = 24; k <= 28; k++) apply(k);
        drain("seg3_drained");

        // TOL=1 instance with alternating 4/5 half-periods.
        tp = '{4, 4, 5, 4, 5};
        for (int k = 0; k <= 3; k++) begin
            repeat (tp[k]) @(negedge clk);
            slow_t = ~slow_t;
        end
        repeat (LAT) @(negedge clk);
        check("tol_not_yet_locked", int'(locked_t), 0);
        check("tol_half_4", int'(half_t), 4);
        repeat (tp[4] - LAT) @(negedge clk);
        slow_t = ~slow_t;
        repeat (LAT) @(negedge clk);
        check("tol_locked", int'(locked_t), 1);
        check("tol_scale", int'(scale_t), 3);
        check("tol_half_5", int'(half_t), 5);
        check("tol_timeout", int'(tmo_t), 0);
        $display("tol lock=%0d scale=%0d half=%0d", locked_t, scale_t, half_t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
